// File: rtl/sync_down_counter_pkg.sv
// Shared types and defaults for the synchronous loadable down counter.
package sync_down_counter_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sync_down_counter_fsm.sv
// Run/terminal-count control for sync_down_counter: decodes load/start/en and
// the count flags into datapath strobes, and registers busy/done.
module sync_down_counter_fsm
   import sync_down_counter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic start,
   input  logic en,
   input  logic q_zero,
   input  logic q_one,
   input  logic auto_rl,
   output logic dec,
   output logic ld,
   output logic go,
   output logic busy,
   output logic done
);

   state_t state_q, state_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;

   always_comb begin
      state_d = state_q;
      dec     = 1'b0;
      ld      = 1'b0;
      go      = 1'b0;
      if (load) begin
         ld      = 1'b1;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start) state_d = q_zero ? ST_DONE : ST_RUN;
            ST_RUN: begin
               if (en) begin
                  dec = 1'b1;
                  if (q_one) state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               // auto_rl is tied low unless periodic reload is built in
               if (auto_rl) begin
                  go      = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/sync_down_counter.sv
// Synchronous loadable WIDTH-bit down counter with one-cycle done pulse.
// Define SYNC_DOWN_COUNTER_AUTO_RELOAD_EN for periodic reload from the last loaded value.
module sync_down_counter
   import sync_down_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             dec, ld, go, auto_rl;

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
   assign auto_rl = (reload_q != '0);
`else
   assign auto_rl = 1'b0;
`endif

   sync_down_counter_fsm u_fsm (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .start   (start),
      .en      (en),
      .q_zero  (q_q == '0),
      .q_one   (q_q == WIDTH'(1)),
      .auto_rl (auto_rl),
      .dec     (dec),
      .ld      (ld),
      .go      (go),
      .busy    (busy),
      .done    (done)
   );

   always_comb begin
      q_d      = q_q;
      reload_d = reload_q;
      if (ld) begin
         q_d      = load_val;
         reload_d = load_val;
      end else if (go) begin
         q_d = reload_q;
      end else if (dec) begin
         q_d = q_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q      <= '0;
         reload_q <= '0;
      end else begin
         q_q      <= q_d;
         reload_q <= reload_d;
      end
   end

   assign q  = q_q;
   assign tc = (q_q == '0);

endmodule
